// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types for the decode-stage RAW hazard scoreboard: register index,
// shadow-pipeline entry and its empty value.
package id_hazard_scoreboard_pkg;

    localparam int unsigned REG_W   = 3;
    localparam int unsigned NUM_ENT = 3;

    typedef logic [REG_W-1:0] lc3b_reg;

    typedef struct packed {
        logic    valid;
        lc3b_reg dr;
        logic    dr_we;
        logic    setcc;
    } lc3b_sb_entry;

    localparam lc3b_sb_entry SB_EMPTY = '{valid: 1'b0, dr: '0, dr_we: 1'b0, setcc: 1'b0};

    // Entry to be pushed into E when an ID instruction issues.
    function automatic lc3b_sb_entry sb_make(input lc3b_reg dr, input logic dr_we, input logic setcc);
        lc3b_sb_entry e;
        e.valid = 1'b1;
        e.dr    = dr;
        e.dr_we = dr_we;
        e.setcc = setcc;
        return e;
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_sb_match.sv
// Compares one in-flight scoreboard entry against both ID source registers
// and reports pending register and condition-code writes.
module sb_match
    import id_hazard_scoreboard_pkg::*;
(
    input  lc3b_sb_entry entry_i,
    input  lc3b_reg      sr1_i,
    input  lc3b_reg      sr2_i,
    output logic         sr1_hit_o,
    output logic         sr2_hit_o,
    output logic         cc_hit_o
);

    logic dr_live;

    assign dr_live   = entry_i.valid & entry_i.dr_we;
    assign sr1_hit_o = dr_live & (entry_i.dr == sr1_i);
    assign sr2_hit_o = dr_live & (entry_i.dr == sr2_i);
    assign cc_hit_o  = entry_i.valid & entry_i.setcc;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage RAW hazard detector: shadows dest regs / CC writes of EX, MEM, WB
// and stalls IF/ID while an ID instruction depends on an unfinished producer.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_sr1,
    input  logic             id_sr1_used,
    input  logic [2:0]       id_sr2,
    input  logic             id_sr2_used,
    input  logic [2:0]       id_dr,
    input  logic             id_dr_we,
    input  logic             id_setcc,
    input  logic             id_usecc,
    input  logic             pipe_freeze,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    lc3b_sb_entry e_q, e_d;
    lc3b_sb_entry m_q, m_d;
    lc3b_sb_entry w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    lc3b_sb_entry         chk_ent [NUM_ENT];
    logic [NUM_ENT-1:0]   sr1_hit;
    logic [NUM_ENT-1:0]   sr2_hit;
    logic [NUM_ENT-1:0]   cc_hit;
    logic                 hazard;
    logic                 issue;

    // W is visible only when the regfile cannot bypass its own write to ID.
    assign chk_ent[0] = e_q;
    assign chk_ent[1] = m_q;
    assign chk_ent[2] = (WB_BYPASS != 0) ? SB_EMPTY : w_q;

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_match
        sb_match u_match (
            .entry_i   (chk_ent[g]),
            .sr1_i     (id_sr1),
            .sr2_i     (id_sr2),
            .sr1_hit_o (sr1_hit[g]),
            .sr2_hit_o (sr2_hit[g]),
            .cc_hit_o  (cc_hit[g])
        );
    end

    assign hazard = id_valid & ((id_sr1_used & (|sr1_hit)) |
                                (id_sr2_used & (|sr2_hit)) |
                                (id_usecc    & (|cc_hit)));
    assign issue  = id_valid & ~hazard;

    assign stall_id    = hazard | pipe_freeze;
    assign ex_bubble   = (hazard | flush) & ~pipe_freeze;
    assign stall_count = cnt_q;

    // Shadow pipeline advance; a freeze holds everything, including a pending flush.
    always_comb begin
        e_d   = e_q;
        m_d   = m_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        if (!pipe_freeze) begin
            w_d = m_q;
            if (flush) begin
                m_d = SB_EMPTY;
                e_d = SB_EMPTY;
            end else begin
                m_d = e_q;
                e_d = issue ? sb_make(id_dr, id_dr_we, id_setcc) : SB_EMPTY;
                if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= SB_EMPTY;
            m_q   <= SB_EMPTY;
            w_q   <= SB_EMPTY;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: three instances (bypass, no bypass, 4-bit counter)
// driven in lockstep against a per-instance reference model and scenario constants.
module tb_id_hazard_scoreboard;
    import id_hazard_scoreboard_pkg::*;

    typedef struct packed {
        logic       v;
        logic [2:0] sr1;
        logic       u1;
        logic [2:0] sr2;
        logic       u2;
        logic [2:0] dr;
        logic       we;
        logic       sc;
        logic       uc;
    } ins_t;

    typedef struct packed {
        logic        chk;
        logic [2:0]  st;
        logic [2:0]  bb;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] c2;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_sr1 = '0;
    logic       id_sr1_used = 1'b0;
    logic [2:0] id_sr2 = '0;
    logic       id_sr2_used = 1'b0;
    logic [2:0] id_dr = '0;
    logic       id_dr_we = 1'b0;
    logic       id_setcc = 1'b0;
    logic       id_usecc = 1'b0;
    logic       pipe_freeze = 1'b0;
    logic       flush = 1'b0;

    logic        st_o [3];
    logic        bb_o [3];
    logic [31:0] cnt_wb1;
    logic [31:0] cnt_wb0;
    logic [3:0]  cnt_sat;
    logic [31:0] cnt_act [3];

    assign cnt_act[0] = cnt_wb1;
    assign cnt_act[1] = cnt_wb0;
    assign cnt_act[2] = 32'(cnt_sat);

    id_hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(32)) u_wb1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_sr1(id_sr1), .id_sr1_used(id_sr1_used), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
        .id_dr(id_dr), .id_dr_we(id_dr_we), .id_setcc(id_setcc), .id_usecc(id_usecc),
        .pipe_freeze(pipe_freeze), .flush(flush),
        .stall_id(st_o[0]), .ex_bubble(bb_o[0]), .stall_count(cnt_wb1));

    id_hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(32)) u_wb0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_sr1(id_sr1), .id_sr1_used(id_sr1_used), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
        .id_dr(id_dr), .id_dr_we(id_dr_we), .id_setcc(id_setcc), .id_usecc(id_usecc),
        .pipe_freeze(pipe_freeze), .flush(flush),
        .stall_id(st_o[1]), .ex_bubble(bb_o[1]), .stall_count(cnt_wb0));

    id_hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_sr1(id_sr1), .id_sr1_used(id_sr1_used), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
        .id_dr(id_dr), .id_dr_we(id_dr_we), .id_setcc(id_setcc), .id_usecc(id_usecc),
        .pipe_freeze(pipe_freeze), .flush(flush),
        .stall_id(st_o[2]), .ex_bubble(bb_o[2]), .stall_count(cnt_sat));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state per instance.
    lc3b_sb_entry me [3];
    lc3b_sb_entry mm [3];
    lc3b_sb_entry mw [3];
    logic [31:0]  mc [3];
    logic         last_haz [3];
    logic         wbp  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0]  cmax [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    exp_t sbq [$];

    function automatic ins_t mk(logic v, logic [2:0] a, logic ua, logic [2:0] b, logic ub,
                                logic [2:0] d, logic we, logic sc, logic uc);
        ins_t i;
        i.v = v; i.sr1 = a; i.u1 = ua; i.sr2 = b; i.u2 = ub;
        i.dr = d; i.we = we; i.sc = sc; i.uc = uc;
        return i;
    endfunction

    function automatic ins_t add(logic [2:0] d, logic [2:0] a, logic [2:0] b);
        return mk(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic ins_t br();
        return mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic ins_t nop();
        return mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic mhaz(int d, ins_t i);
        lc3b_sb_entry ch [3];
        logic h1, h2, hc;
        ch[0] = me[d];
        ch[1] = mm[d];
        ch[2] = wbp[d] ? '0 : mw[d];
        h1 = 1'b0; h2 = 1'b0; hc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ch[k].valid && ch[k].dr_we && ch[k].dr == i.sr1) h1 = 1'b1;
            if (ch[k].valid && ch[k].dr_we && ch[k].dr == i.sr2) h2 = 1'b1;
            if (ch[k].valid && ch[k].setcc) hc = 1'b1;
        end
        return i.v & ((i.u1 & h1) | (i.u2 & h2) | (i.uc & hc));
    endfunction

    // Apply inputs, push expectations, advance the model, then wait for the sample edge.
    task automatic drive(ins_t i, logic frz, logic fl, logic rst);
        exp_t e;
        logic h;
        reset = rst; pipe_freeze = frz; flush = fl;
        id_valid = i.v; id_sr1 = i.sr1; id_sr1_used = i.u1; id_sr2 = i.sr2; id_sr2_used = i.u2;
        id_dr = i.dr; id_dr_we = i.we; id_setcc = i.sc; id_usecc = i.uc;
        e.chk = ~rst;
        for (int d = 0; d < 3; d++) begin
            h = mhaz(d, i);
            last_haz[d] = h;
            e.st[d] = h | frz;
            e.bb[d] = (h | fl) & ~frz;
            if (d == 0) e.c0 = mc[d];
            else if (d == 1) e.c1 = mc[d];
            else e.c2 = mc[d];
            if (rst) begin
                me[d] = '0; mm[d] = '0; mw[d] = '0; mc[d] = '0;
            end else if (!frz) begin
                mw[d] = mm[d];
                if (fl) begin
                    mm[d] = '0; me[d] = '0;
                end else begin
                    mm[d] = me[d];
                    me[d] = (i.v && !h) ? sb_make(i.dr, i.we, i.sc) : '0;
                    if (h && mc[d] != cmax[d]) mc[d] = mc[d] + 32'd1;
                end
            end
        end
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(ins_t i, logic frz, logic fl, logic rst);
        drive(i, frz, fl, rst);
        tick();
    endtask

    // Hold an instruction in ID until the model lets it issue; count observed stalls/bubbles.
    task automatic issue_until(ins_t i, int focus, output int stalls, output int bubbles);
        stalls = 0; bubbles = 0;
        for (int n = 0; n < 10; n++) begin
            drive(i, 1'b0, 1'b0, 1'b0);
            if (st_o[focus] === 1'b1) stalls++;
            if (bb_o[focus] === 1'b1) bubbles++;
            tick();
            if (!last_haz[focus]) break;
        end
    endtask

    // Scoreboard monitor: every driven cycle is compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ec;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
                for (int d = 0; d < 3; d++) begin
                    ec = (d == 0) ? e.c0 : ((d == 1) ? e.c1 : e.c2);
                    n_total++;
                    if (st_o[d] !== e.st[d])
                        $display("FAIL sb_stall_id[%0d] t=%0t got=%b exp=%b", d, $time, st_o[d], e.st[d]);
                    else n_pass++;
                    n_total++;
                    if (bb_o[d] !== e.bb[d])
                        $display("FAIL sb_ex_bubble[%0d] t=%0t got=%b exp=%b", d, $time, bb_o[d], e.bb[d]);
                    else n_pass++;
                    n_total++;
                    if (cnt_act[d] !== ec)
                        $display("FAIL sb_stall_count[%0d] t=%0t got=%0d exp=%0d", d, $time, cnt_act[d], ec);
                    else n_pass++;
                end
            end
        end
    end

    task automatic do_reset();
        step(nop(), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        drive(nop(), 1'b1, 1'b0, 1'b0);
        n_total++;
        if (st_o[0] !== 1'b1 || bb_o[0] !== 1'b0)
            $display("FAIL reset_freeze got st=%b bb=%b exp st=1 bb=0", st_o[0], bb_o[0]);
        else n_pass++;
        tick();
        drive(nop(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (st_o[0] !== 1'b0 || bb_o[0] !== 1'b0 || cnt_wb1 !== 32'd0)
            $display("FAIL reset_idle got st=%b bb=%b cnt=%0d exp 0/0/0", st_o[0], bb_o[0], cnt_wb1);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back(int focus, int exp_stalls);
        int s, b;
        do_reset();
        step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
        issue_until(add(3'd2, 3'd1, 3'd3), focus, s, b);
        n_total++;
        if (s != exp_stalls || b != exp_stalls)
            $display("FAIL b2b[%0d] got stalls=%0d bubbles=%0d exp=%0d", focus, s, b, exp_stalls);
        else n_pass++;
        drive(nop(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (cnt_act[focus] !== 32'(exp_stalls))
            $display("FAIL b2b_count[%0d] got=%0d exp=%0d", focus, cnt_act[focus], exp_stalls);
        else n_pass++;
        tick();
    endtask

    task automatic test_cc();
        int s, b;
        do_reset();
        step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
        issue_until(br(), 0, s, b);
        n_total++;
        if (s != 2) $display("FAIL cc_busy got stalls=%0d exp=2", s);
        else n_pass++;
        do_reset();
        step(mk(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        drive(br(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (st_o[0] !== 1'b0 || st_o[1] !== 1'b0)
            $display("FAIL cc_free got st=%b/%b exp 0/0", st_o[0], st_o[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_same_reg();
        int s, b;
        do_reset();
        drive(add(3'd1, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (st_o[0] !== 1'b0) $display("FAIL self_dep got st=%b exp=0", st_o[0]);
        else n_pass++;
        tick();
        issue_until(add(3'd0, 3'd1, 3'd1), 0, s, b);
        drive(nop(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (s != 2 || cnt_wb1 !== 32'd2)
            $display("FAIL sr1_eq_sr2 got stalls=%0d cnt=%0d exp 2/2", s, cnt_wb1);
        else n_pass++;
        tick();
    endtask

    task automatic test_freeze();
        int s, b;
        do_reset();
        step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            drive(add(3'd2, 3'd1, 3'd3), 1'b1, (n == 2) ? 1'b1 : 1'b0, 1'b0);
            n_total++;
            if (st_o[0] !== 1'b1 || bb_o[0] !== 1'b0 || cnt_wb1 !== 32'd0)
                $display("FAIL freeze[%0d] got st=%b bb=%b cnt=%0d exp 1/0/0", n, st_o[0], bb_o[0], cnt_wb1);
            else n_pass++;
            tick();
        end
        issue_until(add(3'd2, 3'd1, 3'd3), 0, s, b);
        drive(nop(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (s != 2 || cnt_wb1 !== 32'd2)
            $display("FAIL freeze_resume got stalls=%0d cnt=%0d exp 2/2", s, cnt_wb1);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
        drive(add(3'd2, 3'd1, 3'd3), 1'b0, 1'b1, 1'b0);
        n_total++;
        if (bb_o[0] !== 1'b1 || st_o[0] !== 1'b1)
            $display("FAIL flush_cycle got st=%b bb=%b exp 1/1", st_o[0], bb_o[0]);
        else n_pass++;
        tick();
        drive(add(3'd3, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (st_o[0] !== 1'b0 || st_o[1] !== 1'b0 || cnt_wb1 !== 32'd0)
            $display("FAIL flush_after got st=%b/%b cnt=%0d exp 0/0/0", st_o[0], st_o[1], cnt_wb1);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
        step(add(3'd2, 3'd1, 3'd3), 1'b0, 1'b0, 1'b0);
        step(add(3'd2, 3'd1, 3'd3), 1'b0, 1'b0, 1'b1);
        drive(add(3'd2, 3'd1, 3'd3), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (st_o[1] !== 1'b0 || bb_o[1] !== 1'b0 || cnt_wb0 !== 32'd0)
            $display("FAIL reset_mid got st=%b bb=%b cnt=%0d exp 0/0/0", st_o[1], bb_o[1], cnt_wb0);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturate();
        int s, b;
        do_reset();
        for (int p = 0; p < 10; p++) begin
            step(add(3'd1, 3'd4, 3'd5), 1'b0, 1'b0, 1'b0);
            issue_until(add(3'd2, 3'd1, 3'd3), 2, s, b);
        end
        drive(nop(), 1'b0, 1'b0, 1'b0);
        n_total++;
        if (cnt_sat !== 4'hF || cnt_wb1 !== 32'd20)
            $display("FAIL saturate got cnt4=%0d cnt32=%0d exp 15/20", cnt_sat, cnt_wb1);
        else n_pass++;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            me[d] = '0; mm[d] = '0; mw[d] = '0; mc[d] = '0; last_haz[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back(0, 2);
        test_back_to_back(1, 3);
        test_cc();
        test_same_reg();
        test_freeze();
        test_flush();
        test_reset_mid();
        test_saturate();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
